// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: holds the PC and keeps one imem read outstanding.
// It presents the fetched word until the datapath acks it, then steps to the sequential or BEQ-taken PC.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        instr_ack,
  input  logic        branch,
  input  logic        zero,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [31:0] pc_r;
  logic [31:0] instr_r;
  logic        instr_valid_r;
  logic [31:0] fetch_count_r;
  logic [31:0] pc_plus4_s;
  logic [31:0] next_pc_s;
  logic        load_instr_s;
  logic        retire_s;

  // A taken BEQ adds the sign-extended word offset to pc+4. The low PC bits stay zero.
  function automatic logic [31:0] next_pc_f(input logic [31:0] pc4,
                                            input logic [31:0] ins,
                                            input logic        take);
    logic [31:0] offset;
    offset = {{14{ins[15]}}, ins[15:0], 2'b00};
    if (take) begin
      next_pc_f = pc4 + offset;
    end else begin
      next_pc_f = pc4;
    end
    next_pc_f[1:0] = 2'b00;
  endfunction

  assign pc_plus4_s = pc_r + 32'd4;
  assign next_pc_s  = next_pc_f(pc_plus4_s, instr_r, branch & zero);

  // Next-state logic: a request handshake, then a response handshake, then a hold until ack.
  always_comb begin
    state_s      = state_r;
    load_instr_s = 1'b0;
    retire_s     = 1'b0;
    case (state_r)
      S_REQ: begin
        if (imem_ready) begin
          state_s = S_WAIT;
        end else begin
          state_s = S_REQ;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          state_s      = S_HOLD;
          load_instr_s = 1'b1;
        end else begin
          state_s = S_WAIT;
        end
      end
      S_HOLD: begin
        if (instr_ack) begin
          state_s  = S_REQ;
          retire_s = 1'b1;
        end else begin
          state_s = S_HOLD;
        end
      end
      default: begin
        state_s = S_REQ;
      end
    endcase
  end

  // State and datapath registers. Reset abandons any fetch in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= S_REQ;
      pc_r          <= RESET_PC;
      instr_r       <= 32'h0000_0000;
      instr_valid_r <= 1'b0;
      fetch_count_r <= 32'd0;
    end else begin
      state_r <= state_s;
      if (load_instr_s) begin
        instr_r       <= imem_rdata;
        instr_valid_r <= 1'b1;
        fetch_count_r <= fetch_count_r + 32'd1;
      end
      if (retire_s) begin
        instr_valid_r <= 1'b0;
        pc_r          <= next_pc_s;
      end
    end
  end

  // The request is gated by reset so imem never sees a request while the core is held in reset.
  assign imem_req    = rst_n & (state_r == S_REQ);
  assign imem_addr   = pc_r;
  assign pc          = pc_r;
  assign pc_plus4    = pc_plus4_s;
  assign instr       = instr_r;
  assign instr_valid = instr_valid_r;
  assign opcode      = instr_r[31:26];
  assign funct       = instr_r[5:0];
  assign fetch_count = fetch_count_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit. Both instances share one stimulus stream.
// The second instance starts at the top of memory so the PC wrap can be checked.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_ack;
  logic        branch;
  logic        zero;

  logic        imem_req,    w_imem_req;
  logic [31:0] imem_addr,   w_imem_addr;
  logic [31:0] instr,       w_instr;
  logic        instr_valid, w_instr_valid;
  logic [5:0]  opcode,      w_opcode;
  logic [5:0]  funct,       w_funct;
  logic [31:0] pc,          w_pc;
  logic [31:0] pc_plus4,    w_pc_plus4;
  logic [31:0] fetch_count, w_fetch_count;

  int n_checks = 0;
  int n_fails  = 0;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .opcode(opcode), .funct(funct),
    .pc(pc), .pc_plus4(pc_plus4), .instr_ack(instr_ack), .branch(branch),
    .zero(zero), .fetch_count(fetch_count)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr(w_instr), .instr_valid(w_instr_valid), .opcode(w_opcode), .funct(w_funct),
    .pc(w_pc), .pc_plus4(w_pc_plus4), .instr_ack(instr_ack), .branch(branch),
    .zero(zero), .fetch_count(w_fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Request accepted at once, data returned the next cycle.
  task automatic fetch(input logic [31:0] data);
    imem_ready = 1'b1;
    tick();
    imem_ready  = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    tick();
    imem_rvalid = 1'b0;
  endtask

  task automatic ack_instr(input logic br, input logic z);
    instr_ack = 1'b1;
    branch    = br;
    zero      = z;
    tick();
    instr_ack = 1'b0;
    branch    = 1'b0;
    zero      = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    instr_ack = 1'b0; branch = 1'b0; zero = 1'b0;

    // Reset held for two cycles.
    tick(); tick();
    check_eq("rst_req",   {31'd0, imem_req}, 32'd0);
    check_eq("rst_pc",    pc, 32'h0000_0000);
    check_eq("rst_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("rst_count", fetch_count, 32'd0);
    check_eq("rst_instr", instr, 32'h0000_0000);
    rst_n = 1'b1;
    #1;
    check_eq("rel_req",  {31'd0, imem_req}, 32'd1);
    check_eq("rel_addr", imem_addr, 32'h0000_0000);

    // Basic fetch.
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    check_eq("wait_req", {31'd0, imem_req}, 32'd0);
    check_eq("wait_valid", {31'd0, instr_valid}, 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'h2008_0005;
    tick();
    imem_rvalid = 1'b0;
    check_eq("f1_valid",  {31'd0, instr_valid}, 32'd1);
    check_eq("f1_opcode", {26'd0, opcode}, 32'h08);
    check_eq("f1_funct",  {26'd0, funct}, 32'h05);
    check_eq("f1_instr",  instr, 32'h2008_0005);
    check_eq("f1_p4",     pc_plus4, 32'h0000_0004);
    ack_instr(1'b0, 1'b0);
    check_eq("f1_req",   {31'd0, imem_req}, 32'd1);
    check_eq("f1_addr",  imem_addr, 32'h0000_0004);
    check_eq("f1_count", fetch_count, 32'd1);
    check_eq("f1_vlow",  {31'd0, instr_valid}, 32'd0);

    // Advance to 0x10, then take a backward BEQ.
    fetch(32'h0000_0000); ack_instr(1'b0, 1'b0);
    fetch(32'h0000_0000); ack_instr(1'b0, 1'b1);
    fetch(32'h0000_0000); ack_instr(1'b1, 1'b0);
    check_eq("seq_addr", imem_addr, 32'h0000_0010);
    fetch(32'h1109_FFFE);
    ack_instr(1'b1, 1'b1);
    check_eq("beq_taken", imem_addr, 32'h0000_000C);
    fetch(32'h0000_0000); ack_instr(1'b0, 1'b0);
    fetch(32'h1109_FFFE);
    ack_instr(1'b1, 1'b0);
    check_eq("beq_not", imem_addr, 32'h0000_0014);

    // Ack, branch, zero and rvalid are ignored outside their states.
    instr_ack = 1'b1; branch = 1'b1; zero = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    instr_ack = 1'b0; branch = 1'b0; zero = 1'b0; imem_rvalid = 1'b0;
    check_eq("ign_pc",    pc, 32'h0000_0014);
    check_eq("ign_req",   {31'd0, imem_req}, 32'd1);
    check_eq("ign_valid", {31'd0, instr_valid}, 32'd0);

    // Stalled request, then a slow response, then a held instruction.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("stall_req",  {31'd0, imem_req}, 32'd1);
      check_eq("stall_addr", imem_addr, 32'h0000_0014);
    end
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      imem_ready = 1'b1;
      tick();
      imem_ready = 1'b0;
      check_eq("slow_req",   {31'd0, imem_req}, 32'd0);
      check_eq("slow_valid", {31'd0, instr_valid}, 32'd0);
    end
    imem_rvalid = 1'b1; imem_rdata = 32'hABCD_1234;
    tick();
    imem_rvalid = 1'b0;
    check_eq("slow_data",  instr, 32'hABCD_1234);
    check_eq("slow_count", fetch_count, 32'd8);
    for (int i = 0; i < 4; i++) begin
      imem_rvalid = 1'b1; imem_rdata = 32'h5555_5555; branch = 1'b1; zero = 1'b1;
      tick();
      check_eq("hold_instr", instr, 32'hABCD_1234);
      check_eq("hold_valid", {31'd0, instr_valid}, 32'd1);
      check_eq("hold_req",   {31'd0, imem_req}, 32'd0);
    end
    imem_rvalid = 1'b0; branch = 1'b0; zero = 1'b0;
    ack_instr(1'b0, 1'b0);
    check_eq("hold_next", imem_addr, 32'h0000_0018);

    // Reset during WAIT drops the fetch.
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    rst_n = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
    tick();
    imem_rvalid = 1'b0;
    check_eq("mid_rst_req",   {31'd0, imem_req}, 32'd0);
    check_eq("mid_rst_pc",    pc, 32'h0000_0000);
    check_eq("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("mid_rst_count", fetch_count, 32'd0);
    rst_n = 1'b1;
    #1;
    check_eq("mid_rel_req",  {31'd0, imem_req}, 32'd1);
    check_eq("mid_rel_addr", imem_addr, 32'h0000_0000);

    // Top-of-memory PC wraps to zero.
    check_eq("wrap_addr0", w_imem_addr, 32'hFFFF_FFFC);
    check_eq("wrap_p4",    w_pc_plus4, 32'h0000_0000);
    fetch(32'h0000_0000);
    ack_instr(1'b0, 1'b0);
    check_eq("wrap_addr", w_imem_addr, 32'h0000_0000);
    check_eq("wrap_req",  {31'd0, w_imem_req}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
